// File: rtl/mem_access_sched.sv
// mem_access_sched: load/store sequencer for the MIPS memory stage.
// Accepts a decoded load/save class, issues at most one req/ack access to
// data memory, performs the register writeback and reports misaligned or
// timed-out accesses with a one-cycle err pulse.
module mem_access_sched #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  load_sel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] alu_result,
    input  logic [4:0]  dest,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Count value held during the last permitted REQ cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [4:0]       wb_addr_q, wb_addr_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             err_q, err_d;

    logic             ready;
    logic             aligned;

    // Saturating increment: the wait counter never wraps back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
    endfunction

    assign ready   = (state_q != ST_REQ);
    assign aligned = (addr[1:0] == 2'b00);

    // Next-state and capture logic; start is only honoured in ready states.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        err_d       = 1'b0;

        case (state_q)
            ST_REQ: begin
                if (mem_ack) begin
                    if (mem_we_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        wb_data_d = mem_rdata;
                        state_d   = ST_WB;
                    end
                end else begin
                    cnt_d = sat_inc(cnt_q);
                    if (cnt_q >= CNT_LAST) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                // IDLE and WB both fall back to IDLE unless a new op is taken.
                state_d = ST_IDLE;
                if (start) begin
                    case (load_sel)
                        2'b01: begin
                            wb_data_d = alu_result;
                            wb_addr_d = dest;
                            state_d   = ST_WB;
                        end
                        2'b10, 2'b11: begin
                            if (aligned) begin
                                mem_addr_d  = addr;
                                mem_wdata_d = wdata;
                                wb_addr_d   = dest;
                                mem_we_d    = ~load_sel[0];
                                cnt_d       = '0;
                                state_d     = ST_REQ;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // State and captured operands; reset clears everything, including data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_en     = (state_q == ST_WB);
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;
    assign err       = err_q;
    // Stall as soon as an aligned memory op is accepted, and throughout REQ.
    assign stall     = (state_q == ST_REQ) | (ready & start & load_sel[1] & aligned);

endmodule

// File: tb/tb_mem_access_sched.sv
// Scoreboard bench for mem_access_sched: the stimulus process queues the
// expected memory requests, writebacks and error pulses with their cycle
// stamps; a negedge monitor pops and compares whenever the DUT shows one.
module tb_mem_access_sched;

    localparam int K_REQ = 0;
    localparam int K_WB  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        int          len;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  load_sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] alu_result;
    logic [4:0]  dest;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    bit  mon_en = 1'b0;
    bit  req_open = 1'b0;
    int  req_len = 0;
    ev_t cur;
    ev_t exp_q[$];

    mem_access_sched #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load_sel   (load_sel),
        .addr       (addr),
        .wdata      (wdata),
        .alu_result (alu_result),
        .dest       (dest),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: output seen with empty scoreboard (cycle %0d)", name, cyc);
    endtask

    task automatic push_req(input int c, input logic [31:0] a, input logic we,
                            input logic [31:0] d, input int len);
        ev_t e;
        e.kind = K_REQ; e.cyc = c; e.a = a; e.d = d; e.we = we; e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic push_wb(input int c, input logic [4:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = K_WB; e.cyc = c; e.a = {27'd0, a}; e.d = d; e.we = 1'b0; e.len = 0;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input int c);
        ev_t e;
        e.kind = K_ERR; e.cyc = c; e.a = '0; e.d = '0; e.we = 1'b0; e.len = 0;
        exp_q.push_back(e);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"},   {31'd0, mem_req}, 32'd0);
        chk({tag, "_mem_we"},    {31'd0, mem_we},  32'd0);
        chk({tag, "_mem_addr"},  mem_addr,         32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,        32'd0);
        chk({tag, "_stall"},     {31'd0, stall},   32'd0);
        chk({tag, "_wb_en"},     {31'd0, wb_en},   32'd0);
        chk({tag, "_wb_addr"},   {27'd0, wb_addr}, 32'd0);
        chk({tag, "_wb_data"},   wb_data,          32'd0);
        chk({tag, "_err"},       {31'd0, err},     32'd0);
    endtask

    // Monitor: pop an expectation for each request start, writeback and error.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_req) begin
                if (!req_open) begin
                    if (exp_q.size() == 0) begin
                        unexpected("req");
                    end else begin
                        cur = exp_q.pop_front();
                        chk("req_kind", cur.kind, K_REQ);
                        chk("req_cycle", cyc, cur.cyc);
                        req_open = 1'b1;
                        req_len  = 0;
                    end
                end
                if (req_open) begin
                    req_len++;
                    chk("req_addr",  mem_addr,            cur.a);
                    chk("req_we",    {31'd0, mem_we},     {31'd0, cur.we});
                    chk("req_wdata", mem_wdata,           cur.d);
                end
            end else if (req_open) begin
                req_open = 1'b0;
                chk("req_len", req_len, cur.len);
            end

            if (wb_en) begin
                if (exp_q.size() == 0) begin
                    unexpected("wb");
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("wb_kind",  e.kind, K_WB);
                    chk("wb_cycle", cyc, e.cyc);
                    chk("wb_addr",  {27'd0, wb_addr}, e.a);
                    chk("wb_data",  wb_data, e.d);
                end
            end

            if (err) begin
                if (exp_q.size() == 0) begin
                    unexpected("err");
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("err_kind",  e.kind, K_ERR);
                    chk("err_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int t;
        rst = 1'b1; start = 1'b0; load_sel = 2'b00; addr = '0; wdata = '0;
        alu_result = '0; dest = '0; mem_ack = 1'b0; mem_rdata = '0;

        // Reset state
        next_cyc();
        next_cyc();
        at_neg();
        chk_all_zero("reset");
        next_cyc();
        rst = 1'b0;
        mon_en = 1'b1;
        next_cyc();

        // Load, ack on the second REQ cycle
        t = cyc;
        start = 1'b1; load_sel = 2'b11; addr = 32'h0000_0010; dest = 5'd7;
        wdata = 32'h0BAD_0001;
        push_req(t + 1, 32'h0000_0010, 1'b0, 32'h0BAD_0001, 2);
        push_wb(t + 3, 5'd7, 32'hDEAD_BEEF);
        at_neg(); chk("load_stall_T", {31'd0, stall}, 32'd1);
        next_cyc(); start = 1'b0;
        at_neg(); chk("load_stall_T1", {31'd0, stall}, 32'd1);
        next_cyc(); mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        at_neg(); chk("load_stall_ack", {31'd0, stall}, 32'd1);
        next_cyc(); mem_ack = 1'b0;
        at_neg(); chk("load_stall_wb", {31'd0, stall}, 32'd0);
        next_cyc();

        // Store, immediate ack
        t = cyc;
        start = 1'b1; load_sel = 2'b10; addr = 32'h0000_0100; wdata = 32'h1234_5678;
        dest = 5'd0;
        push_req(t + 1, 32'h0000_0100, 1'b1, 32'h1234_5678, 1);
        at_neg(); chk("store_stall_T", {31'd0, stall}, 32'd1);
        next_cyc(); start = 1'b0; mem_ack = 1'b1;
        at_neg(); chk("store_stall_req", {31'd0, stall}, 32'd1);
        next_cyc(); mem_ack = 1'b0;
        at_neg(); chk("store_stall_after", {31'd0, stall}, 32'd0);
        next_cyc();

        // Class 01 followed by a load accepted in the WB cycle
        t = cyc;
        start = 1'b1; load_sel = 2'b01; alu_result = 32'h0000_0055; dest = 5'd3;
        push_wb(t + 1, 5'd3, 32'h0000_0055);
        at_neg(); chk("alu_stall_T", {31'd0, stall}, 32'd0);
        next_cyc();
        load_sel = 2'b11; addr = 32'h0000_0020; dest = 5'd9; wdata = 32'h0000_0000;
        push_req(t + 2, 32'h0000_0020, 1'b0, 32'h0000_0000, 1);
        push_wb(t + 3, 5'd9, 32'hCAFE_F00D);
        at_neg(); chk("b2b_stall_wb", {31'd0, stall}, 32'd1);
        next_cyc(); start = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        at_neg(); chk("b2b_stall_req", {31'd0, stall}, 32'd1);
        next_cyc(); mem_ack = 1'b0;
        at_neg(); chk("b2b_stall_wb2", {31'd0, stall}, 32'd0);
        next_cyc();

        // Timeout: store with no ack, TIMEOUT = 4
        t = cyc;
        start = 1'b1; load_sel = 2'b10; addr = 32'h0000_0200; wdata = 32'hA5A5_A5A5;
        push_req(t + 1, 32'h0000_0200, 1'b1, 32'hA5A5_A5A5, 4);
        push_err(t + 5);
        next_cyc(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            at_neg(); chk("tmo_stall_req", {31'd0, stall}, 32'd1);
            next_cyc();
        end
        at_neg();
        chk("tmo_stall_after", {31'd0, stall}, 32'd0);
        chk("tmo_req_after", {31'd0, mem_req}, 32'd0);
        next_cyc();
        at_neg(); chk("tmo_req_idle", {31'd0, mem_req}, 32'd0);
        next_cyc();

        // Misaligned load
        t = cyc;
        start = 1'b1; load_sel = 2'b11; addr = 32'h0000_0013; dest = 5'd5;
        push_err(t + 1);
        at_neg(); chk("mis_stall_T", {31'd0, stall}, 32'd0);
        next_cyc(); start = 1'b0;
        at_neg(); chk("mis_stall_T1", {31'd0, stall}, 32'd0);
        next_cyc();

        // Reset during the second REQ cycle, then a stray ack
        t = cyc;
        start = 1'b1; load_sel = 2'b11; addr = 32'h0000_0040; dest = 5'd4;
        wdata = 32'h0000_0000;
        push_req(t + 1, 32'h0000_0040, 1'b0, 32'h0000_0000, 2);
        next_cyc(); start = 1'b0;
        next_cyc(); rst = 1'b1;
        at_neg(); chk("rst_stall_req", {31'd0, stall}, 32'd1);
        next_cyc(); rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0BAD;
        at_neg(); chk_all_zero("midrst");
        next_cyc(); mem_ack = 1'b0;
        at_neg();
        chk("stray_wb_en", {31'd0, wb_en}, 32'd0);
        chk("stray_err",   {31'd0, err},   32'd0);
        next_cyc();
        at_neg();
        chk("stray_wb_en2", {31'd0, wb_en}, 32'd0);
        chk("stray_err2",   {31'd0, err},   32'd0);
        next_cyc();
        next_cyc();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        chk("req_closed", {31'd0, req_open}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
